// File: rtl/voice_sequencer.sv
// Timed player for the 4-bit voice-enable switches: steps through a small
// (mask, duration) table at a prescaled tempo, with optional looping.
module voice_sequencer #(
  parameter  int STEPS    = 8,
  parameter  int DUR_W    = 8,
  parameter  int PRESCALE = 1000,
  localparam int IDX_W    = $clog2(STEPS),
  localparam int PW       = $clog2(PRESCALE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [3:0]       wr_mask,
  input  logic [DUR_W-1:0] wr_dur,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  output logic [3:0]       switches,
  output logic             busy,
  output logic [IDX_W-1:0] step_idx,
  output logic             done,
  output logic             dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_PLAY = 1'b1} state_t;

  localparam logic [PW-1:0]    PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(STEPS - 1);

  logic [3:0]       r_mask [STEPS];
  logic [DUR_W-1:0] r_dur  [STEPS];

  state_t           r_state,    w_state_nx;
  logic [3:0]       r_switches, w_sw_nx;
  logic [IDX_W-1:0] r_step_idx, w_idx_nx;
  logic             r_done,     w_done_nx;
  logic [PW-1:0]    r_presc,    w_presc_nx;
  logic [DUR_W-1:0] r_cnt,      w_cnt_nx;

  logic [IDX_W-1:0] w_next_idx;
  logic             w_end;

  // The running step lives in r_switches/r_cnt, so table writes never
  // disturb it; new values are picked up only when an entry is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STEPS; i++) begin
        r_mask[i] <= '0;
        r_dur[i]  <= '0;
      end
    end else if (wr_en) begin
      r_mask[wr_addr] <= wr_mask;
      r_dur[wr_addr]  <= wr_dur;
    end
  end

  assign w_next_idx = r_step_idx + 1'b1;
  assign w_end      = (r_step_idx == IDX_LAST) || (r_dur[w_next_idx] == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_switches <= '0;
      r_step_idx <= '0;
      r_done     <= 1'b0;
      r_presc    <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_switches <= w_sw_nx;
      r_step_idx <= w_idx_nx;
      r_done     <= w_done_nx;
      r_presc    <= w_presc_nx;
      r_cnt      <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_sw_nx    = r_switches;
    w_idx_nx   = r_step_idx;
    w_done_nx  = 1'b0;
    w_presc_nx = r_presc;
    w_cnt_nx   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_sw_nx    = '0;
        w_idx_nx   = '0;
        w_presc_nx = '0;
        w_cnt_nx   = '0;
        if (start && !stop) begin
          if (r_dur[0] != '0) begin
            w_state_nx = S_PLAY;
            w_sw_nx    = r_mask[0];
            w_cnt_nx   = r_dur[0];
          end else begin
            w_done_nx = 1'b1;
          end
        end
      end
      S_PLAY: begin
        if (stop) begin
          w_state_nx = S_IDLE;
          w_sw_nx    = '0;
          w_idx_nx   = '0;
          w_presc_nx = '0;
          w_cnt_nx   = '0;
        end else if (r_presc == PRESC_MAX) begin
          w_presc_nx = '0;
          if (r_cnt > DUR_W'(1)) begin
            w_cnt_nx = r_cnt - 1'b1;
          end else if (!w_end) begin
            w_idx_nx = w_next_idx;
            w_sw_nx  = r_mask[w_next_idx];
            w_cnt_nx = r_dur[w_next_idx];
          end else if (loop && (r_dur[0] != '0)) begin
            w_idx_nx = '0;
            w_sw_nx  = r_mask[0];
            w_cnt_nx = r_dur[0];
          end else begin
            // Natural end of pattern: the only path that raises done.
            w_state_nx = S_IDLE;
            w_sw_nx    = '0;
            w_idx_nx   = '0;
            w_cnt_nx   = '0;
            w_done_nx  = 1'b1;
          end
        end else begin
          w_presc_nx = r_presc + 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign switches  = r_switches;
  assign busy      = (r_state == S_PLAY);
  assign step_idx  = r_step_idx;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_voice_sequencer.sv
// Directed bench for voice_sequencer with PRESCALE=4, STEPS=8, DUR_W=8.
module tb_voice_sequencer;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_mask;
  logic [7:0] wr_dur;
  logic       start;
  logic       stop;
  logic       loop;
  logic [3:0] switches;
  logic       busy;
  logic [2:0] step_idx;
  logic       done;
  logic       dbg_state;

  int n_cmp;
  int n_bad;

  voice_sequencer #(.STEPS(8), .DUR_W(8), .PRESCALE(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_mask(wr_mask), .wr_dur(wr_dur), .start(start), .stop(stop),
    .loop(loop), .switches(switches), .busy(busy), .step_idx(step_idx),
    .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one segment = n consecutive cycles with the same loop input and outputs
  typedef struct {
    logic       loop_in;
    int         n;
    logic [3:0] sw;
    logic       busy;
    logic [2:0] idx;
    logic       done;
  } seg_t;

  seg_t segs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string name, input logic [3:0] e_sw, input logic e_busy,
                            input logic [2:0] e_idx, input logic e_done);
    chk({name, ".switches"}, 32'(switches), 32'(e_sw));
    chk({name, ".busy"}, 32'(busy), 32'(e_busy));
    chk({name, ".dbg_state"}, 32'(dbg_state), 32'(e_busy));
    chk({name, ".step_idx"}, 32'(step_idx), 32'(e_idx));
    chk({name, ".done"}, 32'(done), 32'(e_done));
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] m, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_mask = m; wr_dur = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_segs(input string name, input int first, input int last);
    for (int s = first; s <= last; s++) begin
      for (int c = 0; c < segs[s].n; c++) begin
        loop = segs[s].loop_in;
        check_outs($sformatf("%s.seg%0d.c%0d", name, s, c), segs[s].sw, segs[s].busy,
                   segs[s].idx, segs[s].done);
        tick();
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_mask = '0; wr_dur = '0;
    start = 1'b0; stop = 1'b0; loop = 1'b0;

    // basic play: 0001 x8, 0010 x4, then done for one cycle
    segs[0]  = '{1'b0, 8, 4'b0001, 1'b1, 3'd0, 1'b0};
    segs[1]  = '{1'b0, 4, 4'b0010, 1'b1, 3'd1, 1'b0};
    segs[2]  = '{1'b0, 1, 4'b0000, 1'b0, 3'd0, 1'b1};
    segs[3]  = '{1'b0, 2, 4'b0000, 1'b0, 3'd0, 1'b0};
    // loop: wraps twice, then loop drops during entry1
    segs[4]  = '{1'b1, 8, 4'b0001, 1'b1, 3'd0, 1'b0};
    segs[5]  = '{1'b1, 4, 4'b0010, 1'b1, 3'd1, 1'b0};
    segs[6]  = '{1'b1, 8, 4'b0001, 1'b1, 3'd0, 1'b0};
    segs[7]  = '{1'b1, 4, 4'b0010, 1'b1, 3'd1, 1'b0};
    segs[8]  = '{1'b1, 8, 4'b0001, 1'b1, 3'd0, 1'b0};
    segs[9]  = '{1'b1, 2, 4'b0010, 1'b1, 3'd1, 1'b0};
    segs[10] = '{1'b0, 2, 4'b0010, 1'b1, 3'd1, 1'b0};
    segs[11] = '{1'b0, 1, 4'b0000, 1'b0, 3'd0, 1'b1};
    segs[12] = '{1'b0, 2, 4'b0000, 1'b0, 3'd0, 1'b0};

    // 1. reset
    tick(); tick();
    check_outs("reset_held", 4'b0, 1'b0, 3'd0, 1'b0);
    rst_n = 1'b1;
    tick();
    check_outs("reset_rel", 4'b0, 1'b0, 3'd0, 1'b0);
    pulse_start();
    check_outs("empty_start", 4'b0, 1'b0, 3'd0, 1'b1);
    tick();
    check_outs("empty_after", 4'b0, 1'b0, 3'd0, 1'b0);

    // 2. basic play
    wr(3'd0, 4'b0001, 8'd2);
    wr(3'd1, 4'b0010, 8'd1);
    wr(3'd2, 4'b1111, 8'd0);
    pulse_start();
    run_segs("basic", 0, 3);

    // 3. loop
    loop = 1'b1;
    pulse_start();
    run_segs("loop", 4, 12);

    // 4. stop during entry0, then start+stop together from idle
    pulse_start();
    for (int c = 0; c < 4; c++) begin
      check_outs($sformatf("stop_pre.c%0d", c), 4'b0001, 1'b1, 3'd0, 1'b0);
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_outs("stop_post", 4'b0, 1'b0, 3'd0, 1'b0);
    tick();
    check_outs("stop_post2", 4'b0, 1'b0, 3'd0, 1'b0);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check_outs("start_stop", 4'b0, 1'b0, 3'd0, 1'b0);
    tick();
    check_outs("start_stop2", 4'b0, 1'b0, 3'd0, 1'b0);

    // 5. live write to the playing entry and its successor
    pulse_start();
    for (int c = 0; c < 8; c++) begin
      check_outs($sformatf("live_e0.c%0d", c), 4'b0001, 1'b1, 3'd0, 1'b0);
      wr_en = (c < 2);
      wr_addr = (c == 0) ? 3'd0 : 3'd1;
      wr_mask = (c == 0) ? 4'b1000 : 4'b0101;
      wr_dur  = (c == 0) ? 8'd1 : 8'd3;
      tick();
    end
    wr_en = 1'b0;
    for (int c = 0; c < 12; c++) begin
      check_outs($sformatf("live_e1.c%0d", c), 4'b0101, 1'b1, 3'd1, 1'b0);
      tick();
    end
    check_outs("live_done", 4'b0, 1'b0, 3'd0, 1'b1);
    tick();

    // 6. full table, last entry exhausts the pattern
    for (int k = 0; k < 8; k++) wr(3'(k), 4'(k + 1), 8'd1);
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 4; c++) begin
        check_outs($sformatf("full.k%0d.c%0d", k, c), 4'(k + 1), 1'b1, 3'(k), 1'b0);
        tick();
      end
    end
    check_outs("full_done", 4'b0, 1'b0, 3'd0, 1'b1);
    tick();
    check_outs("full_after", 4'b0, 1'b0, 3'd0, 1'b0);

    // reset mid-play: outputs clear before the next clock edge
    pulse_start();
    repeat (6) tick();
    check_outs("pre_rst", 4'd2, 1'b1, 3'd1, 1'b0);
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 4'b0, 1'b0, 3'd0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    check_outs("rst_table_empty", 4'b0, 1'b0, 3'd0, 1'b1);
    tick();
    check_outs("rst_table_after", 4'b0, 1'b0, 3'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/voice_sequencer.md
# voice_sequencer

Timed controller for the sound card's 4-bit voice-enable switches. It holds a small pattern table of (voice mask, duration) steps and plays them in order. Each step drives `switches` for a programmed number of tempo ticks, with optional looping. It sits between the host/configuration logic and the sound card's `switches` input, replacing manual switch control with a scheduled sequence.

## Interface
- `STEPS`, 8, number of pattern entries; power of two, ≥2
- `DUR_W`, 8, width of the per-step duration field, in ticks
- `PRESCALE`, 1000, clock cycles per tempo tick; ≥2

- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `wr_en`  in  1  pattern-table write strobe
- `wr_addr`  in  log2(STEPS)  entry written
- `wr_mask`  in  4  voice mask stored at `wr_addr`
- `wr_dur`  in  DUR_W  duration stored at `wr_addr`; 0 marks end-of-pattern
- `start`  in  1  begin playback at entry 0; single-cycle or level
- `stop`  in  1  abort playback
- `loop`  in  1  at end of pattern, restart at entry 0 instead of finishing; sampled at each end-of-pattern
- `switches`  out  4  voice enables to the sound card
- `busy`  out  1  high while in PLAY
- `step_idx`  out  log2(STEPS)  index of the entry currently playing
- `done`  out  1  one-cycle pulse when playback ends naturally

## Operation
- Reset values:
  - all table entries are mask=0, dur=0
  - FSM is IDLE
  - `switches`=0, `busy`=0, `step_idx`=0, `done`=0
  - prescaler and duration counters are 0
- Table writes:
  - accepted every cycle in any state
  - a write to the entry currently playing does not alter the running step; the new values take effect the next time that entry is loaded
- **IDLE**: `switches`=0, `busy`=0.
  - `start` with `stop` low loads entry 0.
  - If dur0≠0: go to PLAY with `switches`=mask0, duration counter = dur0, prescaler cleared.
  - If dur0=0: stay IDLE and pulse `done`.
- **PLAY**:
  - The prescaler counts 0..PRESCALE-1. A tick occurs when it wraps.
  - Each tick decrements the duration counter.
  - When the counter reaches 0, advance to the next step:
    - the next index is `step_idx`+1
    - end-of-pattern is either the next entry having dur=0 or `step_idx`=STEPS-1 being exhausted
  - At end-of-pattern:
    - `loop`=1: reload entry 0. If dur0=0 at that moment, finish as if `loop`=0.
    - `loop`=0: go to IDLE, `switches`=0, `step_idx`=0, pulse `done`.
  - Otherwise load the next entry (mask, dur) and clear the prescaler.
- `stop` in PLAY: next cycle IDLE, `switches`=0, `step_idx`=0, no `done`.
- `stop` and `start` asserted in the same cycle: `stop` wins.
- `start` while in PLAY is ignored. It does not restart playback.
- `rst_n` low mid-playback: all outputs return to reset values immediately (asynchronously); the table is cleared.

## Timing
- `start` sampled at edge N: from edge N+1, `busy`=1, `switches`=mask0, `step_idx`=0.
- Each step k drives its mask for exactly dur_k×PRESCALE cycles. The next mask appears on the edge immediately after the final tick, with no gap cycle.
- End of pattern:
  - `done` is high for the one cycle after the last step's final tick.
  - `busy` falls and `switches` become 0 on that same edge.
- Loop wrap: mask0 follows the last step with no gap cycle and no `done`.
- `stop` sampled at edge N: `switches`=0 and `busy`=0 from edge N+1.
- Duration arithmetic: the counter is DUR_W bits wide and never decremented below 0. The maximum step length is (2^DUR_W−1)×PRESCALE cycles.

## Test plan
Bench uses PRESCALE=4, STEPS=8, DUR_W=8.

1. **Reset:** hold `rst_n` low, then release. Required: `switches`=0, `busy`=0, `done`=0, `step_idx`=0; `start` with an empty table produces a `done` pulse the next cycle and `busy` stays 0.
2. **Basic play:** write entry0={0001,2}, entry1={0010,1}, entry2 dur=0; `loop`=0; pulse `start`. Required sequence:
   - `switches`=0001 for 8 cycles
   - then 0010 for 4 cycles
   - then 0, with `done` high for 1 cycle and `busy` low
3. **Loop:** same table with `loop`=1. Required: 0001×8, 0010×4, 0001×8, …, with no `done`. Drop `loop` during entry1; the pattern ends after entry1 with `done`.
4. **Stop and simultaneity:**
   - `stop` at cycle 5 of entry0: `switches`=0 the next cycle, no `done`.
   - `start` and `stop` together from IDLE: `busy` stays 0.
5. **Live write:** during entry0 playback, rewrite entry0 to {1000,1} and entry1 to {0101,3}. Required: the current step keeps 0001 for its full 8 cycles, then 0101 for 12 cycles.
6. **Full table and reset mid-play:**
   - Fill all 8 entries with dur=1 and distinct masks. Required: 8 steps × 4 cycles, `step_idx` 0→7, then `done`.
   - Assert `rst_n` mid-step. Required: immediate `switches`=0, and the table reads back empty (a subsequent `start` gives an immediate `done`).
